// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared state encoding and Booth pair constants
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ADD   = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [1:0] BOOTH_SUB = 2'b10;
  localparam logic [1:0] BOOTH_ADD = 2'b01;

endpackage

// File: rtl/booth_uc.sv
// rtl/booth_uc.sv - control FSM sequencing load, add/sub and shift steps
module booth_uc
  import booth_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic q0,
  input  logic q_1,
  input  logic cnt_zero,
  output logic load,
  output logic add,
  output logic sub,
  output logic shift,
  output logic busy,
  output logic done
);

  state_t state_q, state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    add     = 1'b0;
    sub     = 1'b0;
    shift   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ADD;
        end
      end
      ADD: begin
        busy = 1'b1;
        case ({q0, q_1})
          BOOTH_SUB: sub = 1'b1;
          BOOTH_ADD: add = 1'b1;
          default:   ;
        endcase
        state_d = SHIFT;
      end
      SHIFT: begin
        busy    = 1'b1;
        shift   = 1'b1;
        // cnt_zero already reflects the post-decrement count
        state_d = cnt_zero ? DONE : ADD;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - sequential radix-2 Booth multiplier datapath and top
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CNT_W = $clog2(N + 1);

  // A carries an extra bit so A - M cannot overflow for M = -2^(N-1)
  logic [N:0]       a_q, a_d;
  logic [N:0]       m_q, m_d;
  logic [N-1:0]     q_q, q_d;
  logic             q1_q, q1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic load, add, sub, shift, cnt_zero;

  assign cnt_zero = (cnt_q == CNT_W'(1));

  booth_uc u_uc (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .q0       (q_q[0]),
    .q_1      (q1_q),
    .cnt_zero (cnt_zero),
    .load     (load),
    .add      (add),
    .sub      (sub),
    .shift    (shift),
    .busy     (busy),
    .done     (done)
  );

  always_comb begin
    a_d   = a_q;
    m_d   = m_q;
    q_d   = q_q;
    q1_d  = q1_q;
    cnt_d = cnt_q;
    if (load) begin
      a_d   = '0;
      m_d   = {multiplicand[N-1], multiplicand};
      q_d   = multiplier;
      q1_d  = 1'b0;
      cnt_d = CNT_W'(N);
    end else if (add) begin
      a_d = a_q + m_q;
    end else if (sub) begin
      a_d = a_q - m_q;
    end else if (shift) begin
      {a_d, q_d, q1_d} = {a_q[N], a_q, q_q};
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      m_q   <= '0;
      q_q   <= '0;
      q1_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      m_q   <= m_d;
      q_q   <= q_d;
      q1_q  <= q1_d;
      cnt_q <= cnt_d;
    end
  end

  assign product = {a_q[N-1:0], q_q};

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb/tb_booth_mult_seq.sv - self-checking bench for booth_mult_seq (N=8)
module tb_booth_mult_seq;

  localparam int N = 8;

  logic           clk;
  logic           reset;
  logic           start;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  int checks;
  int failures;

  booth_mult_seq #(.N(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]   m;
    logic [N-1:0]   q;
    logic [2*N-1:0] p;
    string          name;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [2*N-1:0] ref_mult(input logic [N-1:0] m, input logic [N-1:0] q);
    logic signed [N-1:0] sm;
    logic signed [N-1:0] sq;
    int p;
    sm = m;
    sq = q;
    p  = int'(sm) * int'(sq);
    return p[2*N-1:0];
  endfunction

  // One full multiplication with cycle-accurate busy/done/product checks
  task automatic run_check(input logic [N-1:0] m, input logic [N-1:0] q,
                           input logic [2*N-1:0] exp, input string name);
    int bad;
    int done_cnt;
    int done_cyc;
    logic [2*N-1:0] p_done;
    bad = 0; done_cnt = 0; done_cyc = 0; p_done = '0;
    @(negedge clk);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start        = 1'b0;
    multiplicand = ~m;
    multiplier   = q ^ 8'h5A;
    for (int c = 1; c <= 20; c++) begin
      if (busy !== ((c <= 2*N) ? 1'b1 : 1'b0)) bad++;
      if (busy === 1'b1 && done === 1'b1) bad++;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = c;
        p_done   = product;
      end
      @(posedge clk);
      #1;
    end
    chk({name, " busy_window"}, bad, 0);
    chk({name, " done_count"}, done_cnt, 1);
    chk({name, " done_cycle"}, done_cyc, 2*N+1);
    chk({name, " product"}, p_done, exp);
    chk({name, " product_held"}, product, exp);
  endtask

  int dcnt;
  int bad;
  logic [N-1:0] rm, rq;

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;

    vecs[0] = '{8'd3,  8'd5,  16'h000F, "3x5"};
    vecs[1] = '{8'hFD, 8'h07, 16'hFFEB, "m3x7"};
    vecs[2] = '{8'h80, 8'h80, 16'h4000, "80x80"};
    vecs[3] = '{8'h80, 8'h7F, 16'hC080, "80x7F"};
    vecs[4] = '{8'h7F, 8'h7F, 16'h3F01, "7Fx7F"};
    vecs[5] = '{8'h80, 8'hFF, 16'h0080, "80xFF"};
    vecs[6] = '{8'hFF, 8'hFF, 16'h0001, "FFxFF"};
    vecs[7] = '{8'h00, 8'h00, 16'h0000, "0x0"};

    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset product", product, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) run_check(vecs[i].m, vecs[i].q, vecs[i].p, vecs[i].name);

    for (int i = 0; i < 25; i++) begin
      rm = N'($urandom);
      rq = N'($urandom);
      run_check(rm, rq, ref_mult(rm, rq), $sformatf("rand%0d", i));
    end

    // start re-asserted in cycles 3 and 17 must be ignored
    @(negedge clk);
    multiplicand = 8'd0;
    multiplier   = 8'h55;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dcnt = 0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 3 || c == 17) begin
        start = 1'b1;
        multiplicand = 8'd7;
        multiplier = 8'd9;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) dcnt++;
      if (c == 17) chk("ignore product", product, 16'h0000);
      if (c == 18) begin
        chk("ignore idle busy", busy, 0);
        chk("ignore idle done", done, 0);
      end
      if (c == 20) chk("ignore no_restart", busy, 0);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk("ignore done_count", dcnt, 1);
    chk("ignore product_final", product, 16'h0000);

    // reset in cycle 7 aborts with no done pulse
    @(negedge clk);
    multiplicand = 8'd3;
    multiplier   = 8'd5;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort product", product, 0);
    @(negedge clk);
    reset = 1'b0;
    dcnt = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dcnt++;
    end
    chk("abort no_done", dcnt, 0);
    run_check(8'd2, 8'hFF, 16'hFFFE, "post_reset 2xFF");

    // back-to-back with start held high
    @(negedge clk);
    multiplicand = 8'd4;
    multiplier   = 8'd4;
    start        = 1'b1;
    @(posedge clk);
    #1;
    bad = 0;
    dcnt = 0;
    for (int c = 1; c <= 36; c++) begin
      if (done === 1'b1) begin
        dcnt++;
        if (c != 17 && c != 35) bad++;
        chk($sformatf("b2b product c%0d", c), product, 16'h0010);
      end
      if (c == 17 || c == 35) chk($sformatf("b2b done c%0d", c), done, 1);
      if (c == 18) chk("b2b idle busy", busy, 0);
      if (c == 19) chk("b2b second accepted", busy, 1);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk("b2b done_count", dcnt, 2);
    chk("b2b stray_done", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
